// File: rtl/floo_pkg.sv
// Shared FlooNoC types: flit header/flit layout and transmit arbiter state encoding.
// No logic; types and helpers only.
// No backpressure involvement.
package floo_pkg;

  typedef struct packed {
    logic       last;
    logic [3:0] dst_id;
    logic [2:0] rsvd;
  } hdr_t;

  typedef struct packed {
    hdr_t        hdr;
    logic [31:0] payload;
  } flit_t;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } vc_tx_state_e;

  // Index width for n entries, never narrower than one bit.
  function automatic int unsigned idx_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/floo_vc_tx_arbiter.sv
// Round-robin VC arbiter with wormhole lock for a single shared physical channel.
// Latency: grant is combinational from candidates (0 cycles); pointer/lock update at the clock.
// Backpressure: only VCs whose downstream ready is high are candidates; a locked VC blocks all others.
module floo_vc_tx_arbiter
  import floo_pkg::*;
#(
  parameter int unsigned NumVc = 2,
  localparam int unsigned VcW  = idx_w(NumVc)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NumVc-1:0] cand,
  input  logic [NumVc-1:0] last,
  output logic [NumVc-1:0] gnt,
  output logic [VcW-1:0]   gnt_idx
);

  vc_tx_state_e   state_q, state_d;
  logic [VcW-1:0] lock_q, lock_d;
  logic [VcW-1:0] rr_q, rr_d;
  logic [VcW-1:0] idx;
  logic           any;

  // State, lock owner and round-robin pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lock_q  <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
      rr_q    <= rr_d;
    end
  end

  // Pick a grant (locked owner, or first candidate from rr_q) and compute the next state.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = rr_q;
    state_d = state_q;
    lock_d  = lock_q;
    rr_d    = rr_q;
    if (state_q == LOCKED) begin
      if (cand[lock_q]) begin
        any     = 1'b1;
        gnt_idx = lock_q;
      end
    end else begin
      for (int i = 0; i < int'(NumVc); i++) begin
        if (!any && cand[idx]) begin
          any     = 1'b1;
          gnt_idx = idx;
        end
        idx = (idx == VcW'(NumVc - 1)) ? '0 : idx + VcW'(1);
      end
    end
    if (any) begin
      gnt[gnt_idx] = 1'b1;
      if (last[gnt_idx]) begin
        state_d = IDLE;
        rr_d    = (gnt_idx == VcW'(NumVc - 1)) ? '0 : gnt_idx + VcW'(1);
      end else begin
        state_d = LOCKED;
        lock_d  = gnt_idx;
      end
    end
  end

endmodule

// File: rtl/stream_fifo_optimal_wrap.sv
// Generic valid/ready FIFO with registered storage (no fall-through).
// Latency: data pushed in cycle t is visible at the output in t+1.
// Backpressure: in_rdy is derived from registered occupancy only (full => low, even on a pop).
module stream_fifo_optimal_wrap #(
  parameter int unsigned Depth = 2,
  parameter type         T     = logic
) (
  input  logic clk,
  input  logic rst_n,
  input  logic test_en,
  input  logic in_vld,
  output logic in_rdy,
  input  T     in_dat,
  output logic out_vld,
  input  logic out_rdy,
  output T     out_dat
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  T                mem [2**PtrW];
  logic [PtrW-1:0] wr_ptr, rd_ptr;
  logic [CntW-1:0] cnt;
  logic            push, pop;

  // Storage has no scan-specific behaviour; test mode is accepted for interface compatibility.
  logic unused_test_en;
  assign unused_test_en = test_en;

  assign in_rdy  = (cnt < CntW'(Depth));
  assign out_vld = (cnt != '0);
  assign out_dat = mem[rd_ptr];
  assign push    = in_vld & in_rdy;
  assign pop     = out_vld & out_rdy;

  function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Write the storage slot under the write pointer on every push.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_dat;
  end

  // Pointers and occupancy; a simultaneous push and pop leaves occupancy unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   cnt <= cnt + CntW'(1);
        2'b01:   cnt <= cnt - CntW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/floo_vc_endpoint.sv
// Bidirectional VC endpoint: per-VC ejection FIFOs on receive, VC arbitration/pass-through on transmit.
// Latency: receive 1 cycle (registered FIFO); transmit 0 cycles (combinational).
// Backpressure: link_ready_o from registered FIFO occupancy; inj_ready_o follows grant and link_ready_i.
// Optional statistics counters enabled by FLOO_VC_ENDPOINT_STATS_EN.
module floo_vc_endpoint #(
  parameter int unsigned NumVirtChannels = 2,
  parameter int unsigned NumPhysChannels = 1,
  parameter type         flit_t          = floo_pkg::flit_t,
  parameter int unsigned RxFifoDepth     = 2,
  parameter int unsigned CntWidth        = 16
) (
  input  logic                                      clk_i,
  input  logic                                      rst_ni,
  input  logic                                      test_enable_i,
  input  logic [NumVirtChannels-1:0]                link_valid_i,
  output logic [NumVirtChannels-1:0]                link_ready_o,
  input  flit_t [NumPhysChannels-1:0]               link_data_i,
  output logic [NumVirtChannels-1:0]                link_valid_o,
  input  logic [NumVirtChannels-1:0]                link_ready_i,
  output flit_t [NumPhysChannels-1:0]               link_data_o,
  output logic [NumVirtChannels-1:0]                ej_valid_o,
  input  logic [NumVirtChannels-1:0]                ej_ready_i,
  output flit_t [NumVirtChannels-1:0]               ej_data_o,
  input  logic [NumVirtChannels-1:0]                inj_valid_i,
  output logic [NumVirtChannels-1:0]                inj_ready_o,
  input  flit_t [NumVirtChannels-1:0]               inj_data_i,
  output logic [NumVirtChannels-1:0][CntWidth-1:0]  rx_cnt_o,
  output logic [NumVirtChannels-1:0][CntWidth-1:0]  tx_cnt_o
);

  import floo_pkg::*;

  localparam int unsigned VcW = idx_w(NumVirtChannels);

  if (!(NumPhysChannels == 1 || NumPhysChannels == NumVirtChannels)) begin : g_bad_cfg
    $fatal(1, "floo_vc_endpoint: NumPhysChannels must be 1 or NumVirtChannels");
  end

  // Receive: one ejection FIFO per VC, fed from the VC's physical channel.
  for (genvar v = 0; v < int'(NumVirtChannels); v++) begin : g_rx
    localparam int unsigned Ph = (NumPhysChannels == 1) ? 0 : v;
    stream_fifo_optimal_wrap #(
      .Depth (RxFifoDepth),
      .T     (flit_t)
    ) i_rx_fifo (
      .clk     (clk_i),
      .rst_n   (rst_ni),
      .test_en (test_enable_i),
      .in_vld  (link_valid_i[v]),
      .in_rdy  (link_ready_o[v]),
      .in_dat  (link_data_i[Ph]),
      .out_vld (ej_valid_o[v]),
      .out_rdy (ej_ready_i[v]),
      .out_dat (ej_data_o[v])
    );
  end

  // Transmit: the link is held quiet while reset is asserted.
  if (NumPhysChannels == 1) begin : g_tx_arb
    logic [NumVirtChannels-1:0] cand, tx_last, gnt;
    logic [VcW-1:0]             gnt_idx;

    assign cand = inj_valid_i & link_ready_i & {NumVirtChannels{rst_ni}};

    // Extract the last-flit marker of every injection stream for the lock logic.
    always_comb begin
      tx_last = '0;
      for (int v = 0; v < int'(NumVirtChannels); v++) tx_last[v] = inj_data_i[v].hdr.last;
    end

    floo_vc_tx_arbiter #(
      .NumVc (NumVirtChannels)
    ) i_tx_arbiter (
      .clk     (clk_i),
      .rst_n   (rst_ni),
      .cand    (cand),
      .last    (tx_last),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
    );

    assign link_valid_o   = gnt;
    assign inj_ready_o    = gnt;
    assign link_data_o[0] = inj_data_i[gnt_idx];

    // Only one VC may use the shared receive channel per cycle, and only while ready.
    a_rx_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(link_valid_i));
    a_rx_ready:  assert property (@(posedge clk_i) disable iff (!rst_ni) (link_valid_i & ~link_ready_o) == '0);
  end else begin : g_tx_pass
    assign link_valid_o = inj_valid_i & link_ready_i & {NumVirtChannels{rst_ni}};
    assign inj_ready_o  = link_ready_i & {NumVirtChannels{rst_ni}};
    assign link_data_o  = inj_data_i;
  end

`ifdef FLOO_VC_ENDPOINT_STATS_EN
  // Per-VC transfer counters, wrapping at 2^CntWidth.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_cnt_o <= '0;
      tx_cnt_o <= '0;
    end else begin
      for (int v = 0; v < int'(NumVirtChannels); v++) begin
        if (link_valid_i[v] & link_ready_o[v]) rx_cnt_o[v] <= rx_cnt_o[v] + CntWidth'(1);
        if (link_valid_o[v] & link_ready_i[v]) tx_cnt_o[v] <= tx_cnt_o[v] + CntWidth'(1);
      end
    end
  end
`else
  assign rx_cnt_o = '0;
  assign tx_cnt_o = '0;
`endif

endmodule

// File: tb/tb_floo_vc_endpoint.sv
// Self-checking bench for floo_vc_endpoint (2 VCs, 1 physical channel, depth-2 FIFOs).
// Reference model: per-VC queues for ejection, packet-level lock/round-robin pointer for injection.
// Directed scenarios followed by randomized traffic.
module tb_floo_vc_endpoint;
  import floo_pkg::*;

  localparam int NVC = 2;
  localparam int D   = 2;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                test_en = 1'b0;
  logic [1:0]          link_valid_i, link_ready_o, link_valid_o, link_ready_i;
  logic [1:0]          ej_valid_o, ej_ready_i, inj_valid_i, inj_ready_o;
  flit_t [0:0]         link_data_i, link_data_o;
  flit_t [1:0]         ej_data_o, inj_data_i;
  logic [1:0][15:0]    rx_cnt_o, tx_cnt_o;

  int n_tests = 0;
  int n_fail  = 0;

  flit_t rxq [NVC][$];
  int    lock = -1;
  int    rr   = 0;
  int    rxc [NVC];
  int    txc [NVC];
  int    pushed;

  always #5 clk = ~clk;

  floo_vc_endpoint #(
    .NumVirtChannels (2),
    .NumPhysChannels (1),
    .flit_t          (flit_t),
    .RxFifoDepth     (D),
    .CntWidth        (16)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .test_enable_i (test_en),
    .link_valid_i  (link_valid_i),
    .link_ready_o  (link_ready_o),
    .link_data_i   (link_data_i),
    .link_valid_o  (link_valid_o),
    .link_ready_i  (link_ready_i),
    .link_data_o   (link_data_o),
    .ej_valid_o    (ej_valid_o),
    .ej_ready_i    (ej_ready_i),
    .ej_data_o     (ej_data_o),
    .inj_valid_i   (inj_valid_i),
    .inj_ready_o   (inj_ready_o),
    .inj_data_i    (inj_data_i),
    .rx_cnt_o      (rx_cnt_o),
    .tx_cnt_o      (tx_cnt_o)
  );

  task automatic check_eq(string tag, logic [63:0] obs, logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic flit_t rand_flit(bit last);
    flit_t f;
    f.hdr.last   = last;
    f.hdr.dst_id = 4'($urandom_range(0, 15));
    f.hdr.rsvd   = '0;
    f.payload    = $urandom();
    return f;
  endfunction

  function automatic int exp_cnt(int c);
`ifdef FLOO_VC_ENDPOINT_STATS_EN
    return c & 16'hFFFF;
`else
    return c & 0;
`endif
  endfunction

  // Which VC the link should carry this cycle, or -1.
  function automatic int exp_grant();
    bit cand [NVC];
    if (!rst_n) return -1;
    for (int v = 0; v < NVC; v++) cand[v] = inj_valid_i[v] && link_ready_i[v];
    if (lock >= 0) return cand[lock] ? lock : -1;
    for (int i = 0; i < NVC; i++) if (cand[(rr + i) % NVC]) return (rr + i) % NVC;
    return -1;
  endfunction

  task automatic model_reset();
    for (int v = 0; v < NVC; v++) begin
      rxq[v].delete();
      rxc[v] = 0;
      txc[v] = 0;
    end
    lock = -1;
    rr   = 0;
  endtask

  task automatic check_all();
    int g;
    logic [1:0] e;
    g = exp_grant();
    e = (g >= 0) ? 2'(1 << g) : 2'b00;
    check_eq("link_valid_o", link_valid_o, e);
    check_eq("inj_ready_o", inj_ready_o, e);
    if (g >= 0) check_eq("link_data_o", link_data_o[0], inj_data_i[g]);
    for (int v = 0; v < NVC; v++) begin
      check_eq($sformatf("link_ready_o[%0d]", v), link_ready_o[v], rxq[v].size() < D);
      check_eq($sformatf("ej_valid_o[%0d]", v), ej_valid_o[v], rxq[v].size() > 0);
      if (rxq[v].size() > 0) check_eq($sformatf("ej_data_o[%0d]", v), ej_data_o[v], rxq[v][0]);
      check_eq($sformatf("rx_cnt_o[%0d]", v), rx_cnt_o[v], exp_cnt(rxc[v]));
      check_eq($sformatf("tx_cnt_o[%0d]", v), tx_cnt_o[v], exp_cnt(txc[v]));
    end
  endtask

  task automatic model_update();
    int g;
    bit psh, pp;
    if (!rst_n) return;
    g = exp_grant();
    for (int v = 0; v < NVC; v++) begin
      psh = link_valid_i[v] && (rxq[v].size() < D);
      pp  = ej_ready_i[v] && (rxq[v].size() > 0);
      if (pp) void'(rxq[v].pop_front());
      if (psh) begin
        rxq[v].push_back(link_data_i[0]);
        rxc[v] = (rxc[v] + 1) & 16'hFFFF;
      end
    end
    if (g >= 0) begin
      txc[g] = (txc[g] + 1) & 16'hFFFF;
      if (inj_data_i[g].hdr.last) begin
        lock = -1;
        rr   = (g + 1) % NVC;
      end else begin
        lock = g;
      end
    end
  endtask

  // Inputs are stable from here until the next posedge; check at negedge, update model at posedge.
  task automatic cycle();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    link_valid_i   = '0;
    ej_ready_i     = 2'b11;
    inj_valid_i    = '0;
    link_ready_i   = 2'b11;
    link_data_i[0] = rand_flit(1'b1);
    inj_data_i[0]  = rand_flit(1'b1);
    inj_data_i[1]  = rand_flit(1'b1);
  endtask

  initial begin
    int v;
    // Reset: link must stay quiet even with injection pending.
    idle_inputs();
    inj_valid_i = 2'b11;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;
    inj_valid_i = '0;
    cycle();

    // Receive back-to-back on VC1.
    for (int k = 0; k < 4; k++) begin
      link_valid_i   = 2'b10;
      link_data_i[0] = rand_flit(1'($urandom_range(0, 1)));
      cycle();
    end
    link_valid_i = '0;
    repeat (2) cycle();

    // Receive full on VC0, then drain.
    ej_ready_i = 2'b10;
    pushed = 0;
    for (int k = 0; k < 8; k++) begin
      if (k == 4) ej_ready_i = 2'b11;
      link_valid_i   = '0;
      link_data_i[0] = rand_flit(1'b1);
      if (pushed < 3 && rxq[0].size() < D) begin
        link_valid_i[0] = 1'b1;
        pushed++;
      end
      cycle();
    end
    check_eq("third_flit_accepted", 64'(rxc[0] == 3 || !rxq[0].size()), 64'(1));
    link_valid_i = '0;
    cycle();

    // Wormhole lock: VC0 3-flit packet while VC1 waits, then rr returns to VC0.
    inj_valid_i   = 2'b11;
    inj_data_i[1] = rand_flit(1'b1);
    for (int k = 0; k < 4; k++) begin
      inj_data_i[0] = rand_flit(k == 2);
      if (k == 3) inj_valid_i[0] = 1'b0;
      cycle();
    end
    inj_valid_i   = 2'b11;
    inj_data_i[0] = rand_flit(1'b1);
    inj_data_i[1] = rand_flit(1'b1);
    cycle();

    // Link backpressure on VC0: only VC1 may go.
    link_ready_i = 2'b10;
    repeat (3) cycle();

    // Reset mid-packet: lock on VC1 and one flit buffered in FIFO0.
    inj_valid_i    = 2'b10;
    inj_data_i[1]  = rand_flit(1'b0);
    ej_ready_i     = 2'b00;
    link_valid_i   = 2'b01;
    link_data_i[0] = rand_flit(1'b1);
    cycle();
    link_valid_i  = '0;
    inj_valid_i   = 2'b11;
    link_ready_i  = 2'b11;
    inj_data_i[0] = rand_flit(1'b1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ej_ready_i = 2'b11;
    cycle();
    inj_valid_i = '0;
    cycle();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      link_valid_i   = '0;
      link_data_i[0] = rand_flit(1'($urandom_range(0, 1)));
      v = $urandom_range(0, NVC - 1);
      if ($urandom_range(0, 3) != 0 && rxq[v].size() < D) link_valid_i[v] = 1'b1;
      ej_ready_i    = 2'($urandom_range(0, 3));
      inj_valid_i   = 2'($urandom_range(0, 3));
      link_ready_i  = 2'($urandom_range(0, 3));
      inj_data_i[0] = rand_flit(1'($urandom_range(0, 2) == 0));
      inj_data_i[1] = rand_flit(1'($urandom_range(0, 2) == 0));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
